baud_rate_gen: RTL

Programmable baud-rate generator for the UART path, replacing fixed divide-by-constant toggle dividers. From the single system clock it produces a receiver oversample tick (OVERSAMPLE × baud) and a transmitter bit tick (1 × baud), both derived from one runtime-loadable divisor so TX and RX can never drift apart. It sits between the clock source and the UART TX/RX engines and supports glitch-free rate changes and receiver phase realignment.

---
 rtl/baud_pkg.sv | 20 ++
 rtl/baud_rate_gen_if.sv | 26 ++
 rtl/baud_prescaler.sv | 69 ++++++
 rtl/baud_rate_gen.sv | 111 +++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants and divisor payload type for the UART baud-rate generator.
package baud_pkg;

  localparam int unsigned BAUD_DIV_W       = 16;
  localparam int unsigned BAUD_FRAC_W      = 4;
  localparam int unsigned BAUD_OVERSAMPLE  = 16;
  localparam int unsigned BAUD_DEFAULT_DIV = 27;
  localparam int unsigned BAUD_MIN_DIV     = 2;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  int_part;
    logic [BAUD_FRAC_W-1:0] frac_part;
  } baud_div_t;

  // Divisors below the minimum would make ticks back-to-back or stuck.
  function automatic logic [BAUD_DIV_W-1:0] baud_neff(input logic [BAUD_DIV_W-1:0] div);
    return (div < BAUD_DIV_W'(BAUD_MIN_DIV)) ? BAUD_DIV_W'(BAUD_MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/baud_rate_gen_if.sv
// Control/status bundle between the UART controller and baud_rate_gen.
interface baud_rate_gen_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
);

  logic              en;
  logic              sync;
  logic              div_load;
  logic [DIV_W-1:0]  div_value;
  logic [FRAC_W-1:0] div_frac;
  logic              rx_tick;
  logic              tx_tick;
  logic              div_pending;

  modport master (
    output en, sync, div_load, div_value, div_frac,
    input  rx_tick, tx_tick, div_pending
  );

  modport slave (
    input  en, sync, div_load, div_value, div_frac,
    output rx_tick, tx_tick, div_pending
  );

endinterface

// File: rtl/baud_prescaler.sv
// Divide-by-Neff prescaler producing the rx terminal-count strobe.
// With BAUD_FRAC_EN defined, a fractional accumulator stretches periods by one cycle on carry.
module baud_prescaler
  import baud_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_n,
  input  logic      en_i,
  input  logic      sync_i,
  input  baud_div_t div_i,
  output logic      term_c_o
);

  logic [BAUD_DIV_W-1:0] cnt_q;
  logic [BAUD_DIV_W-1:0] cnt_d;
  logic [BAUD_DIV_W-1:0] last_c;
  logic                  clear_c;

`ifdef BAUD_FRAC_EN
  logic [BAUD_FRAC_W-1:0] acc_q;
  logic [BAUD_FRAC_W-1:0] acc_d;
  logic [BAUD_FRAC_W:0]   acc_sum_c;
  logic                   stretch_q;
  logic                   stretch_d;
`else
  logic frac_unused;
  assign frac_unused = ^div_i.frac_part;
`endif

  // Terminal detect; disable and sync both restart the period with no tick.
  always_comb begin
    clear_c = !en_i || sync_i;
    last_c  = baud_neff(div_i.int_part) - BAUD_DIV_W'(1);
`ifdef BAUD_FRAC_EN
    last_c  = last_c + BAUD_DIV_W'(stretch_q);
`endif
    term_c_o = !clear_c && (cnt_q >= last_c);
    cnt_d    = (clear_c || term_c_o) ? '0 : cnt_q + BAUD_DIV_W'(1);
`ifdef BAUD_FRAC_EN
    acc_sum_c = {1'b0, acc_q} + {1'b0, div_i.frac_part};
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (clear_c) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (term_c_o) begin
      acc_d     = acc_sum_c[BAUD_FRAC_W-1:0];
      stretch_d = acc_sum_c[BAUD_FRAC_W];
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
`ifdef BAUD_FRAC_EN
      acc_q     <= '0;
      stretch_q <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
`ifdef BAUD_FRAC_EN
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
`endif
    end
  end

endmodule

// File: rtl/baud_rate_gen.sv
// Programmable baud-rate generator: rx oversample tick and tx bit tick from one divisor.
// Optional fractional divisor enabled by defining BAUD_FRAC_EN.
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W       = BAUD_DIV_W,
  parameter int unsigned OVERSAMPLE  = BAUD_OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV = BAUD_DEFAULT_DIV,
  parameter int unsigned FRAC_W      = BAUD_FRAC_W
) (
  input logic            clk_in,
  input logic            rst_n,
  baud_rate_gen_if.slave bus_io
);

  localparam int unsigned     OS_W      = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam baud_div_t       RESET_DIV = {BAUD_DIV_W'(DEFAULT_DIV), BAUD_FRAC_W'(0)};

  logic [DIV_W-1:0]  div_value_w;
  logic [FRAC_W-1:0] div_frac_w;

  baud_div_t       load_val_c;
  baud_div_t       active_q;
  baud_div_t       active_d;
  baud_div_t       shadow_q;
  baud_div_t       shadow_d;
  logic [OS_W-1:0] os_q;
  logic [OS_W-1:0] os_d;
  logic            rx_tick_q;
  logic            rx_tick_d;
  logic            tx_tick_q;
  logic            tx_tick_d;
  logic            pending_q;
  logic            pending_d;
  logic            term_c;
  logic            restart_c;
  logic            apply_new_c;
  logic            apply_shadow_c;

  assign div_value_w = bus_io.div_value;
  assign div_frac_w  = bus_io.div_frac;

  baud_prescaler u_prescaler (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en_i     (bus_io.en),
    .sync_i   (bus_io.sync),
    .div_i    (active_q),
    .term_c_o (term_c)
  );

  // Divisor hand-over happens only on period boundaries so ticks never glitch.
  always_comb begin
    load_val_c     = {BAUD_DIV_W'(div_value_w), BAUD_FRAC_W'(div_frac_w)};
    restart_c      = !bus_io.en || bus_io.sync;
    apply_new_c    = bus_io.div_load && bus_io.en && bus_io.sync;
    apply_shadow_c = pending_q && (restart_c || term_c) && !apply_new_c;

    shadow_d = bus_io.div_load ? load_val_c : shadow_q;

    active_d = active_q;
    if (apply_new_c) begin
      active_d = load_val_c;
    end else if (apply_shadow_c) begin
      active_d = shadow_q;
    end

    pending_d = pending_q;
    if (apply_new_c) begin
      pending_d = 1'b0;
    end else if (bus_io.div_load) begin
      pending_d = 1'b1;
    end else if (apply_shadow_c) begin
      pending_d = 1'b0;
    end

    os_d = os_q;
    if (restart_c) begin
      os_d = '0;
    end else if (term_c) begin
      os_d = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
    end

    rx_tick_d = term_c;
    tx_tick_d = term_c && (os_q == OS_LAST);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= RESET_DIV;
      shadow_q  <= RESET_DIV;
      os_q      <= '0;
      rx_tick_q <= 1'b0;
      tx_tick_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      os_q      <= os_d;
      rx_tick_q <= rx_tick_d;
      tx_tick_q <= tx_tick_d;
      pending_q <= pending_d;
    end
  end

  assign bus_io.rx_tick     = rx_tick_q;
  assign bus_io.tx_tick     = tx_tick_q;
  assign bus_io.div_pending = pending_q;

endmodule
